// File: rtl/mem_sys_pkg.sv
// Shared definitions for the memory subsystem (cache, arbiter).
// Holds the arbiter state encoding and the default transfer-counter width.
package mem_sys_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int MEM_CNT_W = 32;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins outright; on a tie the
// requester that was not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  assign gnt = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester to one-port memory arbiter with round-robin grant and
// per-requester completed-transfer counters. Data paths are pass-through.
module mem_arbiter
  import mem_sys_pkg::*;
#(
  parameter int CNT_W = MEM_CNT_W
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             mem_valid_m0,
  input  logic             mem_instr_m0,
  input  logic [31:0]      mem_addr_m0,
  input  logic [31:0]      mem_wdata_m0,
  input  logic [3:0]       mem_wstrb_m0,
  output logic             mem_ready_m0,
  output logic [31:0]      mem_rdata_m0,

  input  logic             mem_valid_m1,
  input  logic             mem_instr_m1,
  input  logic [31:0]      mem_addr_m1,
  input  logic [31:0]      mem_wdata_m1,
  input  logic [3:0]       mem_wstrb_m1,
  output logic             mem_ready_m1,
  output logic [31:0]      mem_rdata_m1,

  output logic             mem_valid_mem,
  output logic             mem_instr_mem,
  output logic [31:0]      mem_addr_mem,
  output logic [31:0]      mem_wdata_mem,
  output logic [3:0]       mem_wstrb_mem,
  input  logic             mem_ready_mem,
  input  logic [31:0]      mem_rdata_mem,

  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt_m0,
  output logic [CNT_W-1:0] xfer_cnt_m1
);

  arb_state_e state;
  logic       gnt;
  logic       last;
  logic       pick;
  logic       gnt_valid;

  rr_pick2 u_rr_pick2 (
    .req  ({mem_valid_m1, mem_valid_m0}),
    .last (last),
    .gnt  (pick)
  );

  assign gnt_valid = gnt ? mem_valid_m1 : mem_valid_m0;
  assign busy      = (state == BUSY);

  // Both requesters see the memory read data unconditionally; only ready is steered.
  assign mem_rdata_m0 = mem_rdata_mem;
  assign mem_rdata_m1 = mem_rdata_mem;
  assign mem_ready_m0 = busy && !gnt && mem_ready_mem;
  assign mem_ready_m1 = busy &&  gnt && mem_ready_mem;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    mem_valid_mem = 1'b0;
    mem_instr_mem = 1'b0;
    mem_addr_mem  = '0;
    mem_wdata_mem = '0;
    mem_wstrb_mem = '0;
    if (busy) begin
      if (gnt) begin
        mem_valid_mem = mem_valid_m1;
        mem_instr_mem = mem_instr_m1;
        mem_addr_mem  = mem_addr_m1;
        mem_wdata_mem = mem_wdata_m1;
        mem_wstrb_mem = mem_wstrb_m1;
      end else begin
        mem_valid_mem = mem_valid_m0;
        mem_instr_mem = mem_instr_m0;
        mem_addr_mem  = mem_addr_m0;
        mem_wdata_mem = mem_wdata_m0;
        mem_wstrb_mem = mem_wstrb_m0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last        <= 1'b1;
      xfer_cnt_m0 <= '0;
      xfer_cnt_m1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid_m0 || mem_valid_m1) begin
            gnt   <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          // A completion takes precedence; otherwise a dropped valid is an abort.
          if (mem_ready_mem) begin
            state <= IDLE;
            last  <= gnt;
            if (gnt) xfer_cnt_m1 <= xfer_cnt_m1 + CNT_W'(1);
            else     xfer_cnt_m0 <= xfer_cnt_m0 + CNT_W'(1);
          end else if (!gnt_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  v;
  logic [1:0]  ins;
  logic [31:0] a  [2];
  logic [31:0] wd [2];
  logic [3:0]  ws [2];
  logic        mrdy;
  logic [31:0] mrd;

  logic          rdy0, rdy1, mv, mi, busy;
  logic [31:0]   rd0, rd1, ma, mwd;
  logic [3:0]    mws;
  logic [CW-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  mem_arbiter #(.CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_valid_m0  (v[0]),
    .mem_instr_m0  (ins[0]),
    .mem_addr_m0   (a[0]),
    .mem_wdata_m0  (wd[0]),
    .mem_wstrb_m0  (ws[0]),
    .mem_ready_m0  (rdy0),
    .mem_rdata_m0  (rd0),
    .mem_valid_m1  (v[1]),
    .mem_instr_m1  (ins[1]),
    .mem_addr_m1   (a[1]),
    .mem_wdata_m1  (wd[1]),
    .mem_wstrb_m1  (ws[1]),
    .mem_ready_m1  (rdy1),
    .mem_rdata_m1  (rd1),
    .mem_valid_mem (mv),
    .mem_instr_mem (mi),
    .mem_addr_mem  (ma),
    .mem_wdata_mem (mwd),
    .mem_wstrb_mem (mws),
    .mem_ready_mem (mrdy),
    .mem_rdata_mem (mrd),
    .busy          (busy),
    .xfer_cnt_m0   (cnt0),
    .xfer_cnt_m1   (cnt1)
  );

  // Reference model: who owns the port, who was served last, completed counts.
  bit m_busy;
  int m_own, m_last, m_done;
  int m_cnt [2];

  int checks = 0;
  int failures = 0;
  int comp [$];
  bit          wr_seen;
  logic [31:0] wr_addr, wr_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    #1;
    check("busy",       32'(busy), 32'(m_busy));
    check("valid_mem",  32'(mv),   m_busy ? 32'(v[m_own])   : 32'd0);
    check("instr_mem",  32'(mi),   m_busy ? 32'(ins[m_own]) : 32'd0);
    check("addr_mem",   ma,        m_busy ? a[m_own]        : 32'd0);
    check("wdata_mem",  mwd,       m_busy ? wd[m_own]       : 32'd0);
    check("wstrb_mem",  32'(mws),  m_busy ? 32'(ws[m_own])  : 32'd0);
    check("ready_m0",   32'(rdy0), (m_busy && m_own == 0) ? 32'(mrdy) : 32'd0);
    check("ready_m1",   32'(rdy1), (m_busy && m_own == 1) ? 32'(mrdy) : 32'd0);
    check("rdata_m0",   rd0, mrd);
    check("rdata_m1",   rd1, mrd);
    check("cnt_m0",     32'(cnt0), 32'(m_cnt[0]));
    check("cnt_m1",     32'(cnt1), 32'(m_cnt[1]));
    if (rdy0 === 1'b1) comp.push_back(0);
    if (rdy1 === 1'b1) comp.push_back(1);
    if (mv === 1'b1 && mrdy && mws != 4'h0) begin
      wr_seen = 1'b1;
      wr_addr = ma;
      wr_data = mwd;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_done = -1;
    if (reset) begin
      m_busy = 1'b0; m_own = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (!m_busy) begin
      if (v != 2'b00) begin
        m_own  = (v == 2'b11) ? 1 - m_last : (v[1] ? 1 : 0);
        m_busy = 1'b1;
      end
    end else if (mrdy) begin
      m_busy = 1'b0;
      m_last = m_own;
      m_cnt[m_own] = (m_cnt[m_own] + 1) % (1 << CW);
      m_done = m_own;
    end else if (!v[m_own]) begin
      m_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; v = 2'b00; mrdy = 1'b0;
    advance();
    reset = 1'b0;
    comp.delete();
  endtask

  // Ready on every busy cycle until n completions or the cycle budget runs out.
  task automatic run_until(input string tag, input int n, input int max_cyc, input bit drop_on_done);
    int cyc = 0;
    while (comp.size() < n && cyc < max_cyc) begin
      mrdy = m_busy;
      mrd  = $urandom;
      settle();
      advance();
      if (drop_on_done && m_done >= 0) v[m_done] = 1'b0;
      cyc++;
    end
    mrdy = 1'b0;
    check({tag, "_done"}, comp.size(), n);
  endtask

  initial begin
    reset = 1'b1; v = 2'b00; ins = 2'b00; mrdy = 1'b0; mrd = 32'h0;
    for (int i = 0; i < 2; i++) begin a[i] = '0; wd[i] = '0; ws[i] = '0; end
    @(negedge clk);
    do_reset();
    settle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt0", 32'(cnt0), 32'd0);

    // Single read with ready after three busy cycles.
    v[0] = 1'b1; a[0] = 32'h100; ws[0] = 4'h0; ins[0] = 1'b0;
    advance();
    for (int i = 0; i < 3; i++) begin settle(); advance(); end
    mrdy = 1'b1; mrd = 32'hDEADBEEF;
    settle();
    check("t1_ready_m0", 32'(rdy0), 32'd1);
    check("t1_rdata_m0", rd0, 32'hDEADBEEF);
    check("t1_ready_m1", 32'(rdy1), 32'd0);
    advance();
    v[0] = 1'b0; mrdy = 1'b0;
    settle();
    check("t1_cnt_m0", 32'(cnt0), 32'd1);

    // Simultaneous requests right after reset: m0 first, then m1 write.
    do_reset();
    wr_seen = 1'b0;
    v = 2'b11; a[0] = 32'h10; ws[0] = 4'h0;
    a[1] = 32'h20; wd[1] = 32'hA5A5A5A5; ws[1] = 4'hF;
    run_until("t2", 2, 20, 1'b1);
    check("t2_first",   comp.size() > 0 ? comp[0] : -1, 32'd0);
    check("t2_second",  comp.size() > 1 ? comp[1] : -1, 32'd1);
    check("t2_wr_seen", 32'(wr_seen), 32'd1);
    check("t2_wr_addr", wr_addr, 32'h20);
    check("t2_wr_data", wr_data, 32'hA5A5A5A5);

    // Fairness: both requesting continuously for ten transfers.
    do_reset();
    v = 2'b11;
    run_until("t3", 10, 60, 1'b0);
    v = 2'b00;
    for (int i = 0; i < comp.size(); i++) check("t3_order", comp[i], i % 2);
    settle();
    check("t3_cnt0", 32'(cnt0), 32'd5);
    check("t3_cnt1", 32'(cnt1), 32'd5);

    // Reset in the middle of an m1 transfer.
    do_reset();
    v = 2'b10; a[1] = 32'h44; a[0] = 32'h88;
    advance();
    settle();
    advance();
    reset = 1'b1;
    settle();
    advance();
    reset = 1'b0; v = 2'b11;
    settle();
    check("t4_valid_mem", 32'(mv), 32'd0);
    check("t4_busy",      32'(busy), 32'd0);
    check("t4_cnt1",      32'(cnt1), 32'd0);
    advance();
    settle();
    check("t4_gnt_m0", ma, 32'h88);
    comp.delete();
    run_until("t4", 1, 10, 1'b1);
    v = 2'b00;
    advance();

    // Abort by m0, then a stray ready while idle.
    v = 2'b01; a[0] = 32'h300;
    settle(); advance();
    settle();
    v[0] = 1'b0;
    settle();
    check("t5_abort_valid", 32'(mv), 32'd0);
    advance();
    settle();
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_cnt0", 32'(cnt0), 32'(m_cnt[0]));
    mrdy = 1'b1;
    settle();
    check("t5_stray_r0", 32'(rdy0), 32'd0);
    check("t5_stray_r1", 32'(rdy1), 32'd0);
    advance();
    mrdy = 1'b0;
    settle();
    check("t5_stray_busy", 32'(busy), 32'd0);

    // Counter wrap: sixteen m1 transfers on a 4-bit counter.
    do_reset();
    v = 2'b10;
    run_until("t6", 16, 80, 1'b0);
    v = 2'b00;
    settle();
    check("t6_wrap", 32'(cnt1), 32'd0);

    // Random traffic with aborts, stray readies and occasional resets.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int x = 0; x < 2; x++) begin
        if (m_done == x || !v[x]) begin
          v[x] = 1'($urandom_range(1, 0));
          if (v[x]) begin
            ins[x] = 1'($urandom_range(1, 0));
            a[x]   = $urandom;
            wd[x]  = $urandom;
            ws[x]  = 4'($urandom_range(15, 0));
          end
        end else if ($urandom_range(15, 0) == 0) begin
          v[x] = 1'b0;
        end
      end
      mrdy  = 1'($urandom_range(1, 0));
      if (m_busy && !v[m_own]) mrdy = 1'b0;
      mrd   = $urandom;
      reset = ($urandom_range(199, 0) == 0);
      settle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
